// File: rtl/ysyx_23060111_dmem_resp.sv
// ---------------------------------------------------------------------------
// ysyx_23060111_dmem_resp
//
// Data-memory responder for the execute stage's load/store interface.
// Services one request at a time from an internal word-organised array.
// The response arrives LATENCY cycles after acceptance. Loads return
// right-aligned data, and stores merge byte lanes. Out-of-range accesses and
// misaligned stores are flagged on m_err.
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   m_ren    - load request
//   m_raddr  - load byte address
//   m_wen    - store request (wins over m_ren when both are high)
//   m_waddr  - store byte address
//   m_wdata  - store data, right-aligned
//   m_wmask  - store size in bytes: 1=SB, 2=SH, 4=SW
//   m_rdata  - load data, right-aligned, held until the next load response
//   m_ready  - one-cycle response strobe
//   m_busy   - request in flight; the core must hold
//   m_err    - error status, valid with m_ready
// ---------------------------------------------------------------------------
module ysyx_23060111_dmem_resp #(
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int          DEPTH   = 4096,
    parameter int          LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m_ren,
    input  logic [31:0] m_raddr,
    input  logic        m_wen,
    input  logic [31:0] m_waddr,
    input  logic [31:0] m_wdata,
    input  logic [31:0] m_wmask,
    output logic [31:0] m_rdata,
    output logic        m_ready,
    output logic        m_busy,
    output logic        m_err
);

    localparam int          IDX_W    = $clog2(DEPTH);
    localparam logic [31:0] SPAN     = 32'(DEPTH) << 2;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;

    logic        req_wr_p0;
    logic [31:0] req_addr_p0;
    logic [31:0] req_wdata_p0;
    logic [31:0] req_size_p0;

    logic [31:0] mem [DEPTH];

    logic        src_wr;
    logic [31:0] src_addr;
    logic [31:0] src_size;
    logic [31:0] rel;
    logic        in_range;
    logic [1:0]  off;
    logic [IDX_W-1:0] idx;
    logic        accept;
    logic        enter_resp;
    logic        resp_err;
    logic [31:0] resp_rdata;

    // A store is illegal for an unknown size or a misaligned half/word.
    function automatic logic store_err(input logic [31:0] size, input logic [1:0] o);
        logic e;
        case (size)
            32'd1:   e = 1'b0;
            32'd2:   e = o[0];
            32'd4:   e = (o != 2'd0);
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    // Replace only the byte lanes selected by size and offset.
    function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                               input logic [31:0] wd,
                                               input logic [31:0] size,
                                               input logic [1:0]  o);
        logic [31:0] w;
        w = old;
        case (size)
            32'd1:   w[{o, 3'b000} +: 8] = wd[7:0];
            32'd2:   if (!o[0]) w[{o, 3'b000} +: 16] = wd[15:0];
            32'd4:   w = wd;
            default: w = old;
        endcase
        return w;
    endfunction

    // Shift the addressed byte down to bit 0 and zero-fill above it.
    function automatic logic [31:0] load_align(input logic [31:0] word, input logic [1:0] o);
        return word >> {o, 3'b000};
    endfunction

    // In IDLE, decode the live request so LATENCY=1 can respond right after acceptance.
    always_comb begin
        if (state == IDLE) begin
            src_wr   = m_wen;
            src_addr = m_wen ? m_waddr : m_raddr;
            src_size = m_wmask;
        end else begin
            src_wr   = req_wr_p0;
            src_addr = req_addr_p0;
            src_size = req_size_p0;
        end
    end

    assign rel        = src_addr - BASE;
    assign in_range   = (src_addr >= BASE) && (rel < SPAN);
    assign off        = src_addr[1:0];
    assign idx        = rel[IDX_W+1:2];
    assign accept     = (state == IDLE) && (m_wen || m_ren);
    assign enter_resp = (accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == 4'd1));
    assign resp_err   = !in_range || (src_wr && store_err(src_size, off));
    assign resp_rdata = in_range ? load_align(mem[idx], off) : 32'd0;

    // ---- stage p0: request capture at acceptance ----
    always_ff @(posedge clk) begin
        if (accept) begin
            req_wr_p0    <= m_wen;
            req_addr_p0  <= src_addr;
            req_wdata_p0 <= m_wdata;
            req_size_p0  <= m_wmask;
        end
    end

    // ---- control: FSM and registered response outputs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            m_rdata <= 32'd0;
            m_ready <= 1'b0;
            m_busy  <= 1'b0;
            m_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        m_busy <= 1'b1;
                        cnt    <= CNT_INIT;
                        state  <= enter_resp ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (enter_resp) state <= RESP;
                    else            cnt   <= cnt - 4'd1;
                end
                RESP: begin
                    state  <= IDLE;
                    m_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            if (enter_resp) begin
                m_ready <= 1'b1;
                m_err   <= resp_err;
                if (!src_wr) m_rdata <= resp_rdata;
            end else begin
                m_ready <= 1'b0;
                m_err   <= 1'b0;
            end
        end
    end

    // ---- stage RESP: store commit at the end of the response cycle ----
    // m_err already holds this request's verdict while in RESP.
    always_ff @(posedge clk) begin
        if ((state == RESP) && req_wr_p0 && !m_err)
            mem[idx] <= lane_merge(mem[idx], req_wdata_p0, req_size_p0, off);
    end

endmodule

// File: tb/tb_ysyx_23060111_dmem_resp.sv
// ---------------------------------------------------------------------------
// Testbench for ysyx_23060111_dmem_resp.
// Two instances: dut0 with LATENCY=2 (main) and dut1 with LATENCY=1.
// A byte-addressed reference memory predicts load data and error flags.
// ---------------------------------------------------------------------------
module tb_ysyx_23060111_dmem_resp;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        ren = 1'b0, wen = 1'b0;
    logic [31:0] raddr = '0, waddr = '0, wdata = '0, wmask = '0;

    logic [31:0] rdata0, rdata1;
    logic        ready0, ready1, busy0, busy1, err0, err1;

    int tests = 0;
    int fails = 0;

    bit   [7:0]  bmem [bit [32:0]];
    logic [31:0] exp_rd [2];

    always #5 clk = ~clk;

    ysyx_23060111_dmem_resp #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(2)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .m_ren(ren & ~sel), .m_raddr(raddr),
        .m_wen(wen & ~sel), .m_waddr(waddr), .m_wdata(wdata), .m_wmask(wmask),
        .m_rdata(rdata0), .m_ready(ready0), .m_busy(busy0), .m_err(err0)
    );

    ysyx_23060111_dmem_resp #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .m_ren(ren & sel), .m_raddr(raddr),
        .m_wen(wen & sel), .m_waddr(waddr), .m_wdata(wdata), .m_wmask(wmask),
        .m_rdata(rdata1), .m_ready(ready1), .m_busy(busy1), .m_err(err1)
    );

    function automatic logic [31:0] o_rdata(); return sel ? rdata1 : rdata0; endfunction
    function automatic logic [31:0] o_ready(); return 32'(sel ? ready1 : ready0); endfunction
    function automatic logic [31:0] o_busy();  return 32'(sel ? busy1 : busy0); endfunction
    function automatic logic [31:0] o_err();   return 32'(sel ? err1 : err0); endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (longint'(a) >= longint'(BASE)) &&
               (longint'(a) < longint'(BASE) + 64'(4 * DEPTH));
    endfunction

    // Reference: a store writes `size` bytes starting at the byte address.
    task automatic model_store(input bit s, input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] size, output bit e);
        bit ok;
        ok = in_rng(a) && ((size == 1) || (size == 2 && a % 2 == 0) || (size == 4 && a % 4 == 0));
        e = !ok;
        if (ok)
            for (int i = 0; i < int'(size); i++)
                bmem[{s, a + 32'(i)}] = d[8*i +: 8];
    endtask

    // Reference: a load returns the bytes from the address to the end of its word.
    task automatic model_load(input bit s, input logic [31:0] a, output bit e);
        logic [31:0] rd;
        rd = '0;
        e  = !in_rng(a);
        if (!e)
            for (int i = 0; i < 4 - int'(a % 4); i++)
                rd[8*i +: 8] = bmem[{s, a + 32'(i)}];
        exp_rd[s] = rd;
    endtask

    // Issue one request at a negedge and check every cycle until idle again.
    task automatic do_req(input bit w, input bit r, input logic [31:0] aw, input logic [31:0] ar,
                          input logic [31:0] d, input logic [31:0] size, input bit hold,
                          input string tag);
        int lat;
        bit e;
        lat = sel ? 1 : 2;
        wen = w; ren = r; waddr = aw; raddr = ar; wdata = d; wmask = size;
        if (w) model_store(sel, aw, d, size, e);
        else   model_load(sel, ar, e);
        @(posedge clk);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            wen = 1'b0;
            ren = hold;
            raddr = BASE + (32'($urandom_range(0, 15)) << 2);
            chk({tag, "_busy"}, o_busy(), 32'd1);
            chk({tag, "_ready"}, o_ready(), 32'(k == lat));
            if (k == lat) begin
                chk({tag, "_err"}, o_err(), 32'(e));
                chk({tag, "_rdata"}, o_rdata(), exp_rd[sel]);
            end
        end
        @(negedge clk);
        ren = 1'b0;
        chk({tag, "_idle_busy"}, o_busy(), 32'd0);
        chk({tag, "_idle_ready"}, o_ready(), 32'd0);
        chk({tag, "_idle_err"}, o_err(), 32'd0);
        chk({tag, "_hold_rdata"}, o_rdata(), exp_rd[sel]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d, sz;
        bit          wr;
        int          pick;

        exp_rd[0] = '0;
        exp_rd[1] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_busy0", 32'(busy0), 32'd0);
        chk("rst_ready0", 32'(ready0), 32'd0);
        chk("rst_err0", 32'(err0), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fill a 16-word window so every later load is defined
        for (int i = 0; i < 16; i++)
            do_req(1'b1, 1'b0, BASE + 32'(4 * i), '0, $urandom, 32'd4, 1'b0, "init");

        // Directed test-plan sequence
        do_req(1'b1, 1'b0, 32'h8000_0010, '0, 32'h1234_5678, 32'd4, 1'b0, "sw");
        do_req(1'b0, 1'b1, '0, 32'h8000_0010, '0, '0, 1'b0, "lw");
        chk("tp_lw", rdata0, 32'h1234_5678);
        do_req(1'b1, 1'b0, 32'h8000_0013, '0, 32'hFFFF_FFAB, 32'd1, 1'b0, "sb");
        do_req(1'b0, 1'b1, '0, 32'h8000_0013, '0, '0, 1'b0, "lb3");
        chk("tp_lb3", rdata0, 32'h0000_00AB);
        do_req(1'b0, 1'b1, '0, 32'h8000_0012, '0, '0, 1'b0, "lh2");
        chk("tp_lh2", rdata0, 32'h0000_AB34);
        do_req(1'b1, 1'b0, 32'h8000_0011, '0, 32'h0000_BEEF, 32'd2, 1'b0, "sh_mis");
        do_req(1'b1, 1'b0, 32'h8000_0012, '0, 32'hDEAD_BEEF, 32'd4, 1'b0, "sw_mis");
        do_req(1'b1, 1'b0, 32'h8000_0010, '0, 32'hDEAD_BEEF, 32'd3, 1'b0, "sz3");
        do_req(1'b0, 1'b1, '0, 32'h8000_0010, '0, '0, 1'b0, "lw_after");
        chk("tp_unchanged", rdata0, 32'hAB34_5678);
        do_req(1'b0, 1'b1, '0, 32'h7FFF_FFFC, '0, '0, 1'b0, "ld_low");
        do_req(1'b1, 1'b0, BASE + 32'(4 * DEPTH), '0, 32'hCAFE_F00D, 32'd4, 1'b0, "st_high");
        do_req(1'b0, 1'b1, '0, BASE, '0, '0, 1'b0, "lw_base");
        do_req(1'b0, 1'b1, '0, 32'h8000_0014, '0, '0, 1'b1, "hold");
        do_req(1'b1, 1'b1, 32'h8000_0024, 32'h8000_0028, 32'h5A5A_A5A5, 32'd4, 1'b0, "both");
        do_req(1'b0, 1'b1, '0, 32'h8000_0024, '0, '0, 1'b0, "lw_both");
        chk("tp_both", rdata0, 32'h5A5A_A5A5);

        // Reset in the middle of a store: the store must not land
        wen = 1'b1; waddr = 32'h8000_0020; wdata = 32'h0BAD_0BAD; wmask = 32'd4;
        @(posedge clk);
        @(negedge clk);
        wen = 1'b0;
        chk("mid_busy", 32'(busy0), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy0), 32'd0);
        chk("mid_rst_ready", 32'(ready0), 32'd0);
        chk("mid_rst_err", 32'(err0), 32'd0);
        chk("mid_rst_rdata", rdata0, 32'd0);
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_idle", 32'(busy0), 32'd0);
        do_req(1'b0, 1'b1, '0, 32'h8000_0020, '0, '0, 1'b0, "lw_old");

        // Randomized traffic against the reference memory
        for (int n = 0; n < 60; n++) begin
            wr   = 1'($urandom_range(0, 1));
            pick = $urandom_range(0, 9);
            if (pick == 0)      a = BASE - 32'($urandom_range(1, 8));
            else if (pick == 1) a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 7));
            else                a = BASE + 32'($urandom_range(0, 63));
            case ($urandom_range(0, 4))
                0:       sz = 32'd1;
                1:       sz = 32'd2;
                2, 3:    sz = 32'd4;
                default: sz = 32'd3;
            endcase
            d = $urandom;
            do_req(wr, !wr, a, a, d, sz, 1'($urandom_range(0, 1)), "rnd");
        end

        // LATENCY=1 instance
        sel = 1'b1;
        @(negedge clk);
        do_req(1'b1, 1'b0, 32'h8000_0040, '0, 32'hC001_D00D, 32'd4, 1'b0, "l1_sw");
        do_req(1'b0, 1'b1, '0, 32'h8000_0041, '0, '0, 1'b1, "l1_lb");
        chk("l1_val", rdata1, 32'h00C0_01D0);
        do_req(1'b1, 1'b0, 32'h8000_0042, '0, 32'h0000_1122, 32'd2, 1'b0, "l1_sh");
        do_req(1'b0, 1'b1, '0, 32'h8000_0040, '0, '0, 1'b0, "l1_lw");
        chk("l1_merge", rdata1, 32'h1122_D00D);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
